// File: rtl/dip_debounce_pkg.sv
// Shared constants and helpers for the DIP switch debounce front end.
package dip_pkg;

    localparam int DIP_W            = 7;
    localparam int DEFAULT_DEBOUNCE = 100000;
    localparam int SIM_DEBOUNCE     = 8;

    // Smallest n with 2**n >= value; callers pass DEBOUNCE_CYCLES+1 so the
    // counter can hold DEBOUNCE_CYCLES-1 with room to spare.
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dip_debounce_if.sv
// Change-event channel from the debouncer to its consumer: a valid/ready
// transfer carrying the mask of toggled switches, plus the sticky overrun flag.
interface dip_debounce_if #(
    parameter int WIDTH = dip_pkg::DIP_W
);

    logic             CHANGE_VALID;
    logic [WIDTH-1:0] CHANGE_MASK;
    logic             CHANGE_READY;
    logic             OVERRUN;

    modport master (
        output CHANGE_VALID,
        output CHANGE_MASK,
        output OVERRUN,
        input  CHANGE_READY
    );

    modport slave (
        input  CHANGE_VALID,
        input  CHANGE_MASK,
        input  OVERRUN,
        output CHANGE_READY
    );

endinterface

// File: rtl/dip_debounce_bit.sv
// One switch: two-flop synchroniser, consecutive-mismatch counter and the
// debounced level. o_toggle pulses in the cycle the stable level flips.
module dip_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = dip_pkg::DEFAULT_DEBOUNCE,
    parameter int CNT_W           = dip_pkg::clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_stable,
    output logic o_toggle
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differ;
    logic             w_expire;

    assign w_differ = (r_sync2 != r_stable);
    assign w_expire = w_differ && (r_cnt == C_LAST);

    // Plain two-stage synchroniser; nothing may sit between the stages.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge value of its neighbours, exactly like the hardware.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive mismatches; any return to the stable level restarts.
    // NOTE: the counter is reset explicitly so a reset mid-debounce forces a
    // full interval again instead of inheriting partial credit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (!w_differ) begin
            r_cnt    <= '0;
        end else if (w_expire) begin
            r_cnt    <= '0;
            r_stable <= r_sync2;
        end else begin
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    assign o_stable = r_stable;
    assign o_toggle = w_expire;

endmodule

// File: rtl/dip_debounce.sv
// DIP switch front end: per-bit debounce plus a valid/ready change event that
// accumulates toggled bits until the consumer accepts them.
module dip_debounce
    import dip_pkg::*;
#(
    parameter int WIDTH           = DIP_W,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter int CNT_W           = clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             CLK,
    input  logic             CPU_RESETN,
    input  logic [WIDTH-1:0] DIP_RAW,
    output logic [WIDTH-1:0] DIP_STABLE,
    dip_debounce_if.master   chg
);

    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_toggle;
    logic [WIDTH-1:0] w_accept;
    logic [WIDTH-1:0] w_pending_nxt;
    logic             w_transfer;
    logic             w_ovr_evt;

    logic [WIDTH-1:0] r_pending;
    logic             r_valid;
    logic             r_overrun;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        dip_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .i_clk    (CLK),
            .i_rst_n  (CPU_RESETN),
            .i_raw    (DIP_RAW[g]),
            .o_stable (w_stable[g]),
            .o_toggle (w_toggle[g])
        );
    end

    // Merge new toggles into the pending mask; an accept only removes the
    // bits that were visible to the consumer, so a coincident toggle survives.
    // NOTE: every output of this block gets a value on every path, so no
    // latch is inferred.
    always_comb begin
        w_transfer    = r_valid & chg.CHANGE_READY;
        w_accept      = w_transfer ? r_pending : '0;
        w_pending_nxt = (r_pending & ~w_accept) | w_toggle;
        w_ovr_evt     = |(w_toggle & r_pending & ~w_accept);
    end

    // Event state: pending mask, registered valid and sticky overrun.
    always_ff @(posedge CLK or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_pending <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            r_valid   <= |w_pending_nxt;
            if (w_ovr_evt) begin
                r_overrun <= 1'b1;
            end else if (w_transfer) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign DIP_STABLE       = w_stable;
    assign chg.CHANGE_VALID = r_valid;
    assign chg.CHANGE_MASK  = r_pending;
    assign chg.OVERRUN      = r_overrun;

endmodule

// File: tb/tb_dip_debounce.sv
// Directed bench for dip_debounce with an 8-cycle debounce interval.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dip_debounce;
    import dip_pkg::*;

    localparam int W  = DIP_W;
    localparam int D  = SIM_DEBOUNCE;
    localparam int CW = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] raw   = '0;
    logic [W-1:0] stable;

    int checks = 0;
    int errors = 0;

    dip_debounce_if #(.WIDTH(W)) chg ();

    dip_debounce #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (CW)
    ) dut (
        .CLK        (clk),
        .CPU_RESETN (rst_n),
        .DIP_RAW    (raw),
        .DIP_STABLE (stable),
        .chg        (chg)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, ending on a falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        chg.CHANGE_READY = 1'b0;
        step(3);
        checks++;
        if ({stable, chg.CHANGE_VALID, chg.CHANGE_MASK, chg.OVERRUN} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: stable=%b valid=%b mask=%b ovr=%b required all 0",
                     stable, chg.CHANGE_VALID, chg.CHANGE_MASK, chg.OVERRUN);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        raw = '0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            checks++;
            if (stable !== '0 || chg.CHANGE_VALID !== 1'b0 || chg.OVERRUN !== 1'b0) begin
                errors++;
                $display("FAIL idle_cycle%0d: stable=%b valid=%b ovr=%b required 0/0/0",
                         i, stable, chg.CHANGE_VALID, chg.OVERRUN);
            end
        end
    endtask

    task automatic test_single_bit();
        raw = 7'b0000001;
        step(9);
        checks++;
        if (stable !== 7'b0000000 || chg.CHANGE_VALID !== 1'b0) begin
            errors++;
            $display("FAIL single_early: stable=%b valid=%b required 0000000/0",
                     stable, chg.CHANGE_VALID);
        end
        step(1);
        checks++;
        if (stable !== 7'b0000001 || chg.CHANGE_VALID !== 1'b1 || chg.CHANGE_MASK !== 7'b0000001) begin
            errors++;
            $display("FAIL single_edge10: stable=%b valid=%b mask=%b required 0000001/1/0000001",
                     stable, chg.CHANGE_VALID, chg.CHANGE_MASK);
        end
        chg.CHANGE_READY = 1'b1;
        step(1);
        chg.CHANGE_READY = 1'b0;
        checks++;
        if (chg.CHANGE_VALID !== 1'b0 || chg.CHANGE_MASK !== 7'b0000000) begin
            errors++;
            $display("FAIL single_accept: valid=%b mask=%b required 0/0000000",
                     chg.CHANGE_VALID, chg.CHANGE_MASK);
        end
    endtask

    // Bit 1 glitches; READY is held high meanwhile, which must be harmless.
    task automatic test_glitch();
        int seg_len [4] = '{5, 2, 7, 20};
        logic seg_lvl [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        chg.CHANGE_READY = 1'b1;
        for (int s = 0; s < 4; s++) begin
            raw[1] = seg_lvl[s];
            for (int c = 0; c < seg_len[s]; c++) begin
                step(1);
                checks++;
                if (stable !== 7'b0000001 || chg.CHANGE_VALID !== 1'b0 || chg.OVERRUN !== 1'b0) begin
                    errors++;
                    $display("FAIL glitch_seg%0d_cyc%0d: stable=%b valid=%b ovr=%b required 0000001/0/0",
                             s, c, stable, chg.CHANGE_VALID, chg.OVERRUN);
                end
            end
        end
        chg.CHANGE_READY = 1'b0;
    endtask

    task automatic test_overrun();
        raw = 7'b0000101;
        step(10);
        checks++;
        if (chg.CHANGE_MASK !== 7'b0000100 || chg.CHANGE_VALID !== 1'b1 || chg.OVERRUN !== 1'b0) begin
            errors++;
            $display("FAIL ovr_bit2: mask=%b valid=%b ovr=%b required 0000100/1/0",
                     chg.CHANGE_MASK, chg.CHANGE_VALID, chg.OVERRUN);
        end
        raw = 7'b0001101;
        step(10);
        checks++;
        if (chg.CHANGE_MASK !== 7'b0001100 || chg.OVERRUN !== 1'b0 || stable !== 7'b0001101) begin
            errors++;
            $display("FAIL ovr_bit3: mask=%b ovr=%b stable=%b required 0001100/0/0001101",
                     chg.CHANGE_MASK, chg.OVERRUN, stable);
        end
        raw = 7'b0001001;
        step(9);
        checks++;
        if (chg.OVERRUN !== 1'b0 || stable !== 7'b0001101) begin
            errors++;
            $display("FAIL ovr_before: ovr=%b stable=%b required 0/0001101",
                     chg.OVERRUN, stable);
        end
        step(1);
        checks++;
        if (chg.OVERRUN !== 1'b1 || chg.CHANGE_MASK !== 7'b0001100 || stable !== 7'b0001001) begin
            errors++;
            $display("FAIL ovr_set: ovr=%b mask=%b stable=%b required 1/0001100/0001001",
                     chg.OVERRUN, chg.CHANGE_MASK, stable);
        end
        chg.CHANGE_READY = 1'b1;
        step(1);
        chg.CHANGE_READY = 1'b0;
        checks++;
        if (chg.CHANGE_MASK !== 7'b0000000 || chg.CHANGE_VALID !== 1'b0 || chg.OVERRUN !== 1'b0) begin
            errors++;
            $display("FAIL ovr_accept: mask=%b valid=%b ovr=%b required 0000000/0/0",
                     chg.CHANGE_MASK, chg.CHANGE_VALID, chg.OVERRUN);
        end
    endtask

    task automatic test_back_to_back();
        raw = 7'b0001101;
        step(10);
        checks++;
        if (chg.CHANGE_MASK !== 7'b0000100 || chg.CHANGE_VALID !== 1'b1) begin
            errors++;
            $display("FAIL b2b_pending: mask=%b valid=%b required 0000100/1",
                     chg.CHANGE_MASK, chg.CHANGE_VALID);
        end
        raw = 7'b0011101;
        step(9);
        chg.CHANGE_READY = 1'b1;
        step(1);
        chg.CHANGE_READY = 1'b0;
        checks++;
        if (chg.CHANGE_MASK !== 7'b0010000 || chg.CHANGE_VALID !== 1'b1 ||
            chg.OVERRUN !== 1'b0 || stable !== 7'b0011101) begin
            errors++;
            $display("FAIL b2b_collide: mask=%b valid=%b ovr=%b stable=%b required 0010000/1/0/0011101",
                     chg.CHANGE_MASK, chg.CHANGE_VALID, chg.OVERRUN, stable);
        end
        chg.CHANGE_READY = 1'b1;
        step(1);
        chg.CHANGE_READY = 1'b0;
        checks++;
        if (chg.CHANGE_VALID !== 1'b0 || chg.CHANGE_MASK !== 7'b0000000) begin
            errors++;
            $display("FAIL b2b_drain: valid=%b mask=%b required 0/0000000",
                     chg.CHANGE_VALID, chg.CHANGE_MASK);
        end
    endtask

    task automatic test_reset_mid();
        raw = 7'h7F;
        step(7);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({stable, chg.CHANGE_VALID, chg.CHANGE_MASK, chg.OVERRUN} !== '0) begin
            errors++;
            $display("FAIL midrst_assert: stable=%b valid=%b mask=%b ovr=%b required all 0",
                     stable, chg.CHANGE_VALID, chg.CHANGE_MASK, chg.OVERRUN);
        end
        step(3);
        checks++;
        if ({stable, chg.CHANGE_VALID, chg.CHANGE_MASK, chg.OVERRUN} !== '0) begin
            errors++;
            $display("FAIL midrst_hold: stable=%b valid=%b mask=%b ovr=%b required all 0",
                     stable, chg.CHANGE_VALID, chg.CHANGE_MASK, chg.OVERRUN);
        end
        rst_n = 1'b1;
        step(9);
        checks++;
        if (stable !== 7'h00 || chg.CHANGE_VALID !== 1'b0) begin
            errors++;
            $display("FAIL midrst_early: stable=%h valid=%b required 00/0",
                     stable, chg.CHANGE_VALID);
        end
        step(1);
        checks++;
        if (stable !== 7'h7F || chg.CHANGE_MASK !== 7'h7F ||
            chg.CHANGE_VALID !== 1'b1 || chg.OVERRUN !== 1'b0) begin
            errors++;
            $display("FAIL midrst_edge10: stable=%h mask=%h valid=%b ovr=%b required 7f/7f/1/0",
                     stable, chg.CHANGE_MASK, chg.CHANGE_VALID, chg.OVERRUN);
        end
        chg.CHANGE_READY = 1'b1;
        step(1);
        chg.CHANGE_READY = 1'b0;
        checks++;
        if (chg.CHANGE_VALID !== 1'b0 || stable !== 7'h7F) begin
            errors++;
            $display("FAIL midrst_accept: valid=%b stable=%h required 0/7f",
                     chg.CHANGE_VALID, stable);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_bit();
        test_glitch();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
